// File: rtl/mu0_control.sv
// mu0_control: fetch/execute sequencer for the MU0 datapath.
// Drives the ALU mode, mux selects, register enables and memory strobes,
// and holds every memory strobe until Mem_Ready completes the access.
// Optional feature macro: MU0_CTRL_INSTR_COUNT_EN adds the Instr_Count
// output, a 16-bit count of instructions leaving EXECUTE.
`timescale 1ns/1ps
module mu0_control #(
   parameter int MEM_TIMEOUT = 0,  // 0 disables the memory wait timeout
   parameter int TIMEOUT_W   = 8   // MEM_TIMEOUT must be < 2**TIMEOUT_W
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_Ready,
   input  logic [3:0]  Opcode,
   input  logic        N,
   input  logic        Z,
   output logic        X_sel,
   output logic        Y_sel,
   output logic        Addr_sel,
   output logic [1:0]  M,
   output logic        Acc_En,
   output logic        PC_En,
   output logic        IR_En,
   output logic        Rd,
   output logic        Wr,
   output logic        Halted,
   output logic        Fault
`ifdef MU0_CTRL_INSTR_COUNT_EN
   ,
   output logic [15:0] Instr_Count
`endif
);

   typedef enum logic [1:0] {S_FETCH, S_EXECUTE, S_HALT, S_FAULT} state_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   localparam logic [1:0] ALU_Y   = 2'd0;  // Q = Y
   localparam logic [1:0] ALU_ADD = 2'd1;  // Q = X + Y
   localparam logic [1:0] ALU_INC = 2'd2;  // Q = X + 1
   localparam logic [1:0] ALU_SUB = 2'd3;  // Q = X - Y

   state_t               state;
   state_t               next_state;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 mem_cycle;
   logic                 timeout_hit;

   // Memory is touched in every fetch and in EXECUTE of LDA/STA/ADD/SUB (opcodes 0-3)
   assign mem_cycle = (state == S_FETCH) ||
                      ((state == S_EXECUTE) && (Opcode[3:2] == 2'b00));

   // The last permitted waiting cycle: the count is about to reach MEM_TIMEOUT
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_cycle && !Mem_Ready &&
                        (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

   // Next-state decode; memory states advance only on a completing cycle
   always_comb begin
      // NOTE: give every always_comb target a default first so no path can infer a latch.
      next_state = state;
      case (state)
         S_FETCH: begin
            if (Mem_Ready)        next_state = S_EXECUTE;
            else if (timeout_hit) next_state = S_FAULT;
         end
         S_EXECUTE: begin
            if (mem_cycle) begin
               if (Mem_Ready)        next_state = S_FETCH;
               else if (timeout_hit) next_state = S_FAULT;
            end else if (Opcode == OP_STP) begin
               next_state = S_HALT;
            end else begin
               next_state = S_FETCH;
            end
         end
         default: next_state = state;  // HALT and FAULT exit only via Reset
      endcase
   end

   // State and wait counter; the counter restarts on completion or state change
   always_ff @(posedge Clk or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (Reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         if ((MEM_TIMEOUT == 0) || Mem_Ready || !mem_cycle || (next_state != state))
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Output decode; Reset forces everything low at once, aborting any access
   always_comb begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      M        = ALU_Y;
      Acc_En   = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Halted   = 1'b0;
      Fault    = 1'b0;
      if (!Reset) begin
         case (state)
            S_FETCH: begin
               Rd    = 1'b1;
               X_sel = 1'b1;
               M     = ALU_INC;
               IR_En = Mem_Ready;
               PC_En = Mem_Ready;
            end
            S_EXECUTE: begin
               case (Opcode)
                  OP_LDA: begin
                     Addr_sel = 1'b1;
                     Rd       = 1'b1;
                     M        = ALU_Y;
                     Acc_En   = Mem_Ready;
                  end
                  OP_STA: begin
                     Addr_sel = 1'b1;
                     Wr       = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     Addr_sel = 1'b1;
                     Rd       = 1'b1;
                     M        = (Opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                     Acc_En   = Mem_Ready;
                  end
                  OP_JMP: begin
                     Y_sel = 1'b1;
                     PC_En = 1'b1;
                  end
                  OP_JGE: begin
                     Y_sel = !N;
                     PC_En = !N;
                  end
                  OP_JNE: begin
                     Y_sel = !Z;
                     PC_En = !Z;
                  end
                  default: ;  // STP and undefined opcodes drive nothing
               endcase
            end
            S_HALT:  Halted = 1'b1;
            default: Fault  = 1'b1;
         endcase
      end
   end

`ifdef MU0_CTRL_INSTR_COUNT_EN
   // Retired-instruction count: every edge leaving EXECUTE, wrapping at 16 bits
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         Instr_Count <= '0;
      else if ((state == S_EXECUTE) && (next_state != S_EXECUTE))
         Instr_Count <= Instr_Count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: table-driven check of mu0_control single-instruction
// behaviour plus hand sequences for waits, halt, timeout and reset.
// Instance a uses MEM_TIMEOUT=4, instance b the default (no timeout).
`timescale 1ns/1ps
module tb_mu0_control;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Mem_Ready = 1'b0;
   logic [3:0] Opcode = 4'h0;
   logic       N = 1'b0;
   logic       Z = 1'b0;

   logic a_x, a_y, a_addr, a_acc, a_pc, a_ir, a_rd, a_wr, a_h, a_f;
   logic b_x, b_y, b_addr, b_acc, b_pc, b_ir, b_rd, b_wr, b_h, b_f;
   logic [1:0] a_m, b_m;
`ifdef MU0_CTRL_INSTR_COUNT_EN
   logic [15:0] a_cnt, b_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   mu0_control #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut_a (
      .Clk(Clk), .Reset(Reset), .Mem_Ready(Mem_Ready), .Opcode(Opcode), .N(N), .Z(Z),
      .X_sel(a_x), .Y_sel(a_y), .Addr_sel(a_addr), .M(a_m), .Acc_En(a_acc),
      .PC_En(a_pc), .IR_En(a_ir), .Rd(a_rd), .Wr(a_wr), .Halted(a_h), .Fault(a_f)
`ifdef MU0_CTRL_INSTR_COUNT_EN
      , .Instr_Count(a_cnt)
`endif
   );

   mu0_control dut_b (
      .Clk(Clk), .Reset(Reset), .Mem_Ready(Mem_Ready), .Opcode(Opcode), .N(N), .Z(Z),
      .X_sel(b_x), .Y_sel(b_y), .Addr_sel(b_addr), .M(b_m), .Acc_En(b_acc),
      .PC_En(b_pc), .IR_En(b_ir), .Rd(b_rd), .Wr(b_wr), .Halted(b_h), .Fault(b_f)
`ifdef MU0_CTRL_INSTR_COUNT_EN
      , .Instr_Count(b_cnt)
`endif
   );

   // Output vector order: {X_sel,Y_sel,Addr_sel,M[1:0],Acc_En,PC_En,IR_En,Rd,Wr,Halted,Fault}
   logic [11:0] a_o, b_o;
   assign a_o = {a_x, a_y, a_addr, a_m, a_acc, a_pc, a_ir, a_rd, a_wr, a_h, a_f};
   assign b_o = {b_x, b_y, b_addr, b_m, b_acc, b_pc, b_ir, b_rd, b_wr, b_h, b_f};

   function automatic logic [11:0] mk(input logic x, input logic y, input logic a,
                                      input logic [1:0] m, input logic acc, input logic pc,
                                      input logic ir, input logic rd, input logic wr,
                                      input logic h, input logic f);
      return {x, y, a, m, acc, pc, ir, rd, wr, h, f};
   endfunction

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        n;
      logic        z;
      logic        rdy;
      logic [11:0] exp_exec;   // outputs in the EXECUTE cycle
      logic [11:0] exp_after;  // outputs one cycle later with Mem_Ready=1
      int          cnt_after;  // instructions retired by then
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input string name, input logic [3:0] op, input logic n,
                                input logic z, input logic rdy, input logic [11:0] ee,
                                input logic [11:0] ea, input int c);
      vec_t v;
      v.name = name; v.op = op; v.n = n; v.z = z; v.rdy = rdy;
      v.exp_exec = ee; v.exp_after = ea; v.cnt_after = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%04h expected=%04h", name, got, exp);
      end
   endtask

   logic [11:0] P_ZERO, P_FR, P_FW, P_LDA_R, P_LDA_W, P_STA, P_ADD_R, P_ADD_W;
   logic [11:0] P_SUB_R, P_SUB_W, P_JMP, P_HALT, P_FAULT;

   // Reset pulse, then release into FETCH with the given Mem_Ready
   task automatic apply_reset(input logic rdy);
      @(negedge Clk);
      Reset = 1'b1; Mem_Ready = 1'b1; Opcode = 4'h0; N = 1'b0; Z = 1'b0;
      #1 check("rst_zero", {4'h0, a_o}, {4'h0, P_ZERO});
      @(negedge Clk);
      Reset = 1'b0; Mem_Ready = rdy;
      #1 check(rdy ? "fetch_ready" : "fetch_wait", {4'h0, a_o}, {4'h0, rdy ? P_FR : P_FW});
   endtask

   initial begin
      logic [3:0] prog[5];
      P_ZERO  = '0;
      P_FR    = mk(1, 0, 0, 2'd2, 0, 1, 1, 1, 0, 0, 0);
      P_FW    = mk(1, 0, 0, 2'd2, 0, 0, 0, 1, 0, 0, 0);
      P_LDA_R = mk(0, 0, 1, 2'd0, 1, 0, 0, 1, 0, 0, 0);
      P_LDA_W = mk(0, 0, 1, 2'd0, 0, 0, 0, 1, 0, 0, 0);
      P_STA   = mk(0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 0, 0);
      P_ADD_R = mk(0, 0, 1, 2'd1, 1, 0, 0, 1, 0, 0, 0);
      P_ADD_W = mk(0, 0, 1, 2'd1, 0, 0, 0, 1, 0, 0, 0);
      P_SUB_R = mk(0, 0, 1, 2'd3, 1, 0, 0, 1, 0, 0, 0);
      P_SUB_W = mk(0, 0, 1, 2'd3, 0, 0, 0, 1, 0, 0, 0);
      P_JMP   = mk(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
      P_HALT  = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
      P_FAULT = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);

      //                      name         op     n     z     rdy   exec     after    cnt
      vecs.push_back(mkv("lda_rdy",   4'h0, 1'b0, 1'b0, 1'b1, P_LDA_R, P_FR,    1));
      vecs.push_back(mkv("lda_wait",  4'h0, 1'b0, 1'b0, 1'b0, P_LDA_W, P_LDA_R, 0));
      vecs.push_back(mkv("sta_rdy",   4'h1, 1'b0, 1'b0, 1'b1, P_STA,   P_FR,    1));
      vecs.push_back(mkv("sta_wait",  4'h1, 1'b0, 1'b0, 1'b0, P_STA,   P_STA,   0));
      vecs.push_back(mkv("add_rdy",   4'h2, 1'b0, 1'b0, 1'b1, P_ADD_R, P_FR,    1));
      vecs.push_back(mkv("sub_rdy",   4'h3, 1'b1, 1'b1, 1'b1, P_SUB_R, P_FR,    1));
      vecs.push_back(mkv("sub_wait",  4'h3, 1'b0, 1'b0, 1'b0, P_SUB_W, P_SUB_R, 0));
      vecs.push_back(mkv("jmp_nordy", 4'h4, 1'b1, 1'b1, 1'b0, P_JMP,   P_FR,    1));
      vecs.push_back(mkv("jge_taken", 4'h5, 1'b0, 1'b1, 1'b1, P_JMP,   P_FR,    1));
      vecs.push_back(mkv("jge_not",   4'h5, 1'b1, 1'b0, 1'b1, P_ZERO,  P_FR,    1));
      vecs.push_back(mkv("jne_taken", 4'h6, 1'b1, 1'b0, 1'b1, P_JMP,   P_FR,    1));
      vecs.push_back(mkv("jne_not",   4'h6, 1'b0, 1'b1, 1'b1, P_ZERO,  P_FR,    1));
      vecs.push_back(mkv("stp",       4'h7, 1'b0, 1'b0, 1'b1, P_ZERO,  P_HALT,  1));
      vecs.push_back(mkv("nop_a",     4'hA, 1'b0, 1'b0, 1'b1, P_ZERO,  P_FR,    1));
      vecs.push_back(mkv("nop_f",     4'hF, 1'b1, 1'b1, 1'b0, P_ZERO,  P_FR,    1));

      // Reset held with Mem_Ready=1: everything low, both instances
      @(negedge Clk);
      Mem_Ready = 1'b1;
      #1 check("rst_a", {4'h0, a_o}, {4'h0, P_ZERO});
      check("rst_b", {4'h0, b_o}, {4'h0, P_ZERO});

      // Table: reset, fetch (ready), one EXECUTE cycle, then one more cycle
      foreach (vecs[i]) begin
         apply_reset(1'b1);
         @(negedge Clk);
         Opcode = vecs[i].op; N = vecs[i].n; Z = vecs[i].z; Mem_Ready = vecs[i].rdy;
         #1 check({vecs[i].name, "_exec"}, {4'h0, a_o}, {4'h0, vecs[i].exp_exec});
         @(negedge Clk);
         Mem_Ready = 1'b1;
         #1 check({vecs[i].name, "_after"}, {4'h0, a_o}, {4'h0, vecs[i].exp_after});
`ifdef MU0_CTRL_INSTR_COUNT_EN
         check({vecs[i].name, "_cnt"}, a_cnt, 16'(vecs[i].cnt_after));
`endif
      end

      // ADD with three wait cycles: outputs held, Acc_En only on completion
      apply_reset(1'b1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clk);
         Opcode = 4'h2; Mem_Ready = 1'b0;
         #1 check($sformatf("add_hold%0d", c), {4'h0, a_o}, {4'h0, P_ADD_W});
      end
      @(negedge Clk);
      Mem_Ready = 1'b1;
      #1 check("add_done", {4'h0, a_o}, {4'h0, P_ADD_R});
      @(negedge Clk);
      Mem_Ready = 1'b0;
      #1 check("add_to_fetch", {4'h0, a_o}, {4'h0, P_FW});

      // STP: Halted for 10 cycles whatever the inputs, then cleared by Reset
      apply_reset(1'b1);
      @(negedge Clk);
      Opcode = 4'h7;
      #1 check("stp_exec", {4'h0, a_o}, {4'h0, P_ZERO});
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         Opcode = 4'($urandom_range(0, 15));
         Mem_Ready = 1'($urandom_range(0, 1));
         #1 check($sformatf("halt%0d", c), {4'h0, a_o}, {4'h0, P_HALT});
      end
      @(negedge Clk);
      Reset = 1'b1;
      #1 check("halt_rst", {4'h0, a_o}, {4'h0, P_ZERO});
      @(negedge Clk);
      Reset = 1'b0; Mem_Ready = 1'b1;
      #1 check("halt_rst_fetch", {4'h0, a_o}, {4'h0, P_FR});

      // Timeout: four waiting fetch cycles, then FAULT; no timeout in instance b
      apply_reset(1'b0);
      check("to_b_1", {4'h0, b_o}, {4'h0, P_FW});
      for (int c = 2; c <= 6; c++) begin
         @(negedge Clk);
         Mem_Ready = 1'b0;
         #1 check($sformatf("to_a_%0d", c), {4'h0, a_o}, {4'h0, (c <= 4) ? P_FW : P_FAULT});
         check($sformatf("to_b_%0d", c), {4'h0, b_o}, {4'h0, P_FW});
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge Clk);
         Mem_Ready = 1'b1;
         #1 check($sformatf("fault_stay%0d", c), {4'h0, a_o}, {4'h0, P_FAULT});
      end

      // Reset in the middle of a waiting fetch: strobes drop without a clock edge
      apply_reset(1'b0);
      #2 Reset = 1'b1;
      #1 check("rst_mid", {4'h0, a_o}, {4'h0, P_ZERO});
      @(negedge Clk);
      Reset = 1'b0; Mem_Ready = 1'b1;
      #1 check("rst_mid_fetch", {4'h0, a_o}, {4'h0, P_FR});

`ifdef MU0_CTRL_INSTR_COUNT_EN
      // Program LDA, STA, JMP, NOP(A), STP with memory always ready
      prog[0] = 4'h0; prog[1] = 4'h1; prog[2] = 4'h4; prog[3] = 4'hA; prog[4] = 4'h7;
      apply_reset(1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         Opcode = prog[i];
         if (i < 4) @(negedge Clk);
      end
      @(negedge Clk);
      #1 check("prog_cnt_a", a_cnt, 16'd5);
      check("prog_cnt_b", b_cnt, 16'd5);
      check("prog_halt", {4'h0, a_o}, {4'h0, P_HALT});
`else
      prog[0] = 4'h0;
      Opcode = prog[0];
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
